// File: rtl/kmap_mux_eval.sv
// kmap_mux_eval -- evaluates a 4-variable function through an external
// 4:1 mux-input encoder. It answers single {a,b,c,d} queries
// (IDLE->EVAL->HOLD) and can also sweep all four K-map columns to build a
// 16-entry truth table (IDLE->SWEEP x4->IDLE).
// Optional feature: define KMAP_EVAL_MINTERM_COUNT_EN to add the
// minterm_count output, which is the popcount of truth_table.
module kmap_mux_eval (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        a,
   input  logic        b,
   input  logic        c,
   input  logic        d,
   output logic [1:0]  cd_out,
   input  logic [3:0]  mux_in,
   output logic        f,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        sweep_start,
   output logic        sweep_busy,
   output logic        sweep_done,
   output logic [15:0] truth_table
`ifdef KMAP_EVAL_MINTERM_COUNT_EN
   ,
   output logic [4:0]  minterm_count
`endif
);

   typedef enum logic [1:0] {IDLE, EVAL, HOLD, SWEEP} state_t;

   state_t      state, state_nxt;
   logic [1:0]  q_ab;          // latched mux select of the accepted query
   logic [1:0]  q_cd;          // latched K-map column of the accepted query
   logic [15:0] shadow;        // truth table being assembled by a sweep
   logic [15:0] shadow_nxt;    // shadow including the current sweep column
   logic        sweep_last;

   assign sweep_last = (state == SWEEP) && (cd_out == 2'd3);

`ifdef KMAP_EVAL_MINTERM_COUNT_EN
   function automatic logic [4:0] popcnt(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
      return n;
   endfunction
`endif

   // Next-state logic and handshake outputs. sweep_start outranks in_valid.
   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      sweep_busy = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~sweep_start;
            if (sweep_start)   state_nxt = SWEEP;
            else if (in_valid) state_nxt = EVAL;
         end
         EVAL: state_nxt = HOLD;
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         SWEEP: begin
            sweep_busy = 1'b1;
            if (sweep_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Merge the current column into the shadow; row ab takes mux_in[ab].
   always_comb begin
      shadow_nxt = shadow;
      if (state == SWEEP)
         for (int i = 0; i < 4; i++) shadow_nxt[{i[1:0], cd_out}] = mux_in[i];
   end

   // State register plus datapath. cd_out only moves on query acceptance or
   // during a sweep, so it holds in IDLE and HOLD. truth_table loads the
   // full shadow in one step at the end of the 4th sweep cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         q_ab        <= '0;
         q_cd        <= '0;
         cd_out      <= '0;
         f           <= 1'b0;
         shadow      <= '0;
         truth_table <= '0;
         sweep_done  <= 1'b0;
`ifdef KMAP_EVAL_MINTERM_COUNT_EN
         minterm_count <= '0;
`endif
      end else begin
         state      <= state_nxt;
         sweep_done <= 1'b0;
         case (state)
            IDLE: begin
               if (sweep_start) begin
                  cd_out <= 2'd0;
               end else if (in_valid) begin
                  q_ab   <= {a, b};
                  q_cd   <= {c, d};
                  cd_out <= {c, d};
               end
            end
            EVAL: f <= mux_in[q_ab];
            SWEEP: begin
               shadow <= shadow_nxt;
               if (sweep_last) begin
                  truth_table <= shadow_nxt;
                  sweep_done  <= 1'b1;
`ifdef KMAP_EVAL_MINTERM_COUNT_EN
                  minterm_count <= popcnt(shadow_nxt);
`endif
               end else begin
                  cd_out <= cd_out + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // q_cd mirrors cd_out for a query; kept so the latched query is complete.
   logic unused_q_cd;
   assign unused_q_cd = ^q_cd;

endmodule

// File: tb/tb_kmap_mux_eval.sv
// Bench for kmap_mux_eval: directed scenarios plus randomized encoder
// tables and queries, checked against a truth-table reference model.
module tb_kmap_mux_eval;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, a, b, c, d;
   logic [1:0]  cd_out;
   logic [3:0]  mux_in;
   logic        f, out_valid, out_ready, sweep_start, sweep_busy, sweep_done;
   logic [15:0] truth_table;
`ifdef KMAP_EVAL_MINTERM_COUNT_EN
   logic [4:0]  minterm_count;
`endif

   int n_chk = 0;
   int n_fail = 0;

   // encoder model: enc[cd] is the mux_in word returned for column cd
   logic [3:0] enc [4];
   logic       scramble;   // corrupts mux_in when the DUT must not sample it

   kmap_mux_eval dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .d(d), .cd_out(cd_out), .mux_in(mux_in),
      .f(f), .out_valid(out_valid), .out_ready(out_ready),
      .sweep_start(sweep_start), .sweep_busy(sweep_busy),
      .sweep_done(sweep_done), .truth_table(truth_table)
`ifdef KMAP_EVAL_MINTERM_COUNT_EN
      , .minterm_count(minterm_count)
`endif
   );

   always #5 clk = ~clk;

   always_comb mux_in = enc[cd_out] ^ {4{scramble}};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference: minterm {a,b,c,d} -> column cd selects word, row ab selects bit
   function automatic logic [15:0] model_tt();
      logic [15:0] t;
      for (int m = 0; m < 16; m++) begin
         logic [3:0] w;
         w = enc[m % 4];
         t[m] = w[m / 4];
      end
      return t;
   endfunction

   function automatic logic model_f(input int ab, input int cd);
      logic [3:0] w;
      w = enc[cd];
      return w[ab];
   endfunction

   task automatic do_sweep(input logic with_query);
      logic [15:0] exp;
      exp = model_tt();
      scramble = 1'b0;
      sweep_start = 1'b1;
      in_valid = with_query;
      {a, b, c, d} = 4'($urandom);
      #1 chk("sweep_start_in_ready", in_ready, 0);
      tick();
      sweep_start = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("sweep_busy", sweep_busy, 1);
         chk("sweep_cd_out", cd_out, k);
         chk("sweep_no_done", sweep_done, 0);
         tick();
      end
      chk("sweep_done", sweep_done, 1);
      chk("sweep_busy_end", sweep_busy, 0);
      chk("sweep_in_ready", in_ready, 1);
      chk("sweep_no_out_valid", out_valid, 0);
      chk("truth_table", truth_table, exp);
`ifdef KMAP_EVAL_MINTERM_COUNT_EN
      chk("minterm_count", minterm_count, $countones(exp));
`endif
      tick();
      chk("sweep_done_pulse", sweep_done, 0);
      chk("tt_hold", truth_table, exp);
   endtask

   task automatic do_query(input logic [3:0] abcd, input int hold, input logic sweep_in_hold);
      logic expf;
      expf = model_f(abcd[3:2], abcd[1:0]);
      scramble = 1'b0;
      in_valid = 1'b1;
      {a, b, c, d} = abcd;
      out_ready = 1'b0;
      #1 chk("q_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      {a, b, c, d} = 4'($urandom);
      chk("eval_cd_out", cd_out, abcd[1:0]);
      chk("eval_out_valid", out_valid, 0);
      chk("eval_in_ready", in_ready, 0);
      tick();
      scramble = 1'b1;
      for (int h = 0; h < hold; h++) begin
         sweep_start = sweep_in_hold;
         #1;
         chk("hold_out_valid", out_valid, 1);
         chk("hold_f", f, expf);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_cd_out", cd_out, abcd[1:0]);
         tick();
      end
      sweep_start = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("hs_out_valid", out_valid, 1);
      chk("hs_f", f, expf);
      tick();
      out_ready = 1'b0;
      chk("post_out_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
      chk("post_sweep_busy", sweep_busy, 0);
      chk("idle_cd_hold", cd_out, abcd[1:0]);
      chk("post_f_hold", f, expf);
      scramble = 1'b0;
   endtask

   initial begin
      enc[0] = 4'b0100; enc[1] = 4'b0001; enc[2] = 4'b0101; enc[3] = 4'b1001;
      scramble = 1'b0;
      reset = 1'b1; in_valid = 1'b0; {a, b, c, d} = 4'd0;
      out_ready = 1'b0; sweep_start = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_f", f, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sweep_busy", sweep_busy, 0);
      chk("rst_sweep_done", sweep_done, 0);
      chk("rst_cd_out", cd_out, 0);
      chk("rst_truth_table", truth_table, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef KMAP_EVAL_MINTERM_COUNT_EN
      chk("rst_minterm_count", minterm_count, 0);
`endif

      // reference sweep and its documented constant
      do_sweep(1'b0);
      chk("tt_850E", truth_table, 16'h850E);

      // a=1,b=0,c=0,d=0 -> f=1; a=1,b=1,c=0,d=1 held 3 cycles -> f=0
      do_query(4'b1000, 0, 1'b0);
      do_query(4'b1101, 3, 1'b0);

      // sweep_start together with in_valid: sweep wins
      do_sweep(1'b1);
      chk("tt_850E_prio", truth_table, 16'h850E);

      // reset in the 3rd sweep cycle aborts
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      tick(); tick();
      chk("abort_busy_before", sweep_busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", sweep_busy, 0);
      chk("abort_done", sweep_done, 0);
      chk("abort_tt", truth_table, 0);
      tick();
      chk("abort_done_late", sweep_done, 0);
      do_sweep(1'b0);
      chk("tt_850E_after_abort", truth_table, 16'h850E);

      // sweep_start during HOLD is ignored
      do_query(4'b0011, 2, 1'b1);
      tick();
      chk("hold_sweep_ignored", sweep_busy, 0);
      chk("hold_sweep_ignored_done", sweep_done, 0);

      // randomized encoder tables and queries
      for (int r = 0; r < 12; r++) begin
         for (int k = 0; k < 4; k++) enc[k] = 4'($urandom);
         do_sweep(1'($urandom));
         for (int q = 0; q < 4; q++) begin
            do_query(4'($urandom), $urandom_range(0, 2), 1'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
